// File: rtl/alu_exec_unit.sv
// alu_exec_unit: RV32IM execute stage, single-cycle ALU plus iterative MUL/DIV.
// Ports: clk, rst_n; in_valid/in_ready + alu_op/func7/func3/op_a/op_b in;
//        out_valid/out_ready + result/zero/illegal out (registered).
module alu_exec_unit #(
   parameter int XLEN   = 32,
   parameter bit MDU_EN = 1'b1
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [1:0]      alu_op,
   input  logic [6:0]      func7,
   input  logic [2:0]      func3,
   input  logic [XLEN-1:0] op_a,
   input  logic [XLEN-1:0] op_b,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] result,
   output logic            zero,
   output logic            illegal
);

   localparam int SH = $clog2(XLEN);
   localparam int CW = $clog2(XLEN);
   localparam logic [CW-1:0] LAST = CW'(XLEN - 1);
   localparam logic [XLEN-1:0] MIN = {1'b1, {(XLEN-1){1'b0}}};

   typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_t;

   typedef enum logic [4:0] {
      OP_ADD  = 5'h00, OP_SLL  = 5'h01, OP_SLT    = 5'h02, OP_SLTU  = 5'h03,
      OP_XOR  = 5'h04, OP_SRL  = 5'h05, OP_OR     = 5'h06, OP_AND   = 5'h07,
      OP_SUB  = 5'h08, OP_SRA  = 5'h09,
      OP_MUL  = 5'h10, OP_MULH = 5'h11, OP_MULHSU = 5'h12, OP_MULHU = 5'h13,
      OP_DIV  = 5'h14, OP_DIVU = 5'h15, OP_REM    = 5'h16, OP_REMU  = 5'h17
   } op_t;

   state_t            state, state_n;
   op_t               op, mop_q;
   logic              bad;
   logic [SH-1:0]     shamt;
   logic [XLEN-1:0]   alu_res, fast_res, m_res;
   logic              is_m, is_div, quo_op, div_zero, div_ovf, fast;
   logic              a_neg, b_neg, accept, finish;
   logic [CW-1:0]     cnt;
   logic [XLEN-1:0]   hi, lo, opnd, hi_n, lo_n;
   logic              sa_q, sb_q;
   logic [XLEN:0]     sum, sh;
   logic [XLEN-1:0]   diff;
   logic              ge;
   logic [2*XLEN-1:0] prod, prod_s;
   logic [XLEN-1:0]   quo, rem;

   always_comb begin
      op  = OP_ADD;
      bad = 1'b0;
      unique case (alu_op)
         2'b00: op = OP_ADD;
         2'b01: op = OP_SUB;
         2'b10: begin
            unique case (1'b1)
               (func7 == 7'h00): op = op_t'({2'b00, func3});
               (func7 == 7'h20 && func3 == 3'b000): op = OP_SUB;
               (func7 == 7'h20 && func3 == 3'b101): op = OP_SRA;
               (func7 == 7'h01 && MDU_EN): op = op_t'({2'b10, func3});
               default: bad = 1'b1;
            endcase
         end
         default: begin
            unique case (func3)
               3'b001: begin
                  op  = OP_SLL;
                  bad = (func7 != 7'h00);
               end
               3'b101: begin
                  op  = (func7 == 7'h20) ? OP_SRA : OP_SRL;
                  bad = (func7 != 7'h00) && (func7 != 7'h20);
               end
               default: op = op_t'({2'b00, func3});
            endcase
         end
      endcase
   end

   assign shamt = op_b[SH-1:0];

   always_comb begin
      alu_res = '0;
      case (op)
         OP_ADD:  alu_res = op_a + op_b;
         OP_SUB:  alu_res = op_a - op_b;
         OP_SLL:  alu_res = op_a << shamt;
         OP_SLT:  alu_res = {{(XLEN-1){1'b0}}, $signed(op_a) < $signed(op_b)};
         OP_SLTU: alu_res = {{(XLEN-1){1'b0}}, op_a < op_b};
         OP_XOR:  alu_res = op_a ^ op_b;
         OP_SRL:  alu_res = op_a >> shamt;
         OP_SRA:  alu_res = $signed(op_a) >>> shamt;
         OP_OR:   alu_res = op_a | op_b;
         OP_AND:  alu_res = op_a & op_b;
         default: alu_res = '0;
      endcase
   end

   // Division corner cases are answered directly instead of iterating.
   assign is_m     = op[4];
   assign is_div   = op[4] & op[2];
   assign quo_op   = is_div & ~op[1];
   assign div_zero = is_div && (op_b == '0);
   assign div_ovf  = is_div && !op[0] && (op_a == MIN) && (op_b == '1);
   assign fast     = bad || !is_m || div_zero || div_ovf;

   always_comb begin
      fast_res = alu_res;
      if (div_zero)
         fast_res = quo_op ? '1 : op_a;
      else if (div_ovf)
         fast_res = quo_op ? MIN : '0;
   end

   assign a_neg = op_a[XLEN-1] &&
      (op == OP_MULH || op == OP_MULHSU || op == OP_DIV || op == OP_REM);
   assign b_neg = op_b[XLEN-1] &&
      (op == OP_MULH || op == OP_DIV || op == OP_REM);

   assign in_ready = (state == S_IDLE) && (!out_valid || out_ready);
   assign accept   = in_valid && in_ready;
   assign finish   = (state != S_IDLE) && (cnt == LAST);

   // hi:lo is the product (multiplier shifts out of lo) or remainder:quotient.
   assign sum  = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : '0);
   assign sh   = {hi, lo[XLEN-1]};
   assign ge   = sh >= {1'b0, opnd};
   assign diff = sh[XLEN-1:0] - opnd;

   always_comb begin
      if (state == S_MUL) begin
         hi_n = sum[XLEN:1];
         lo_n = {sum[0], lo[XLEN-1:1]};
      end else begin
         hi_n = ge ? diff : sh[XLEN-1:0];
         lo_n = {lo[XLEN-2:0], ge};
      end
   end

   assign prod   = {hi_n, lo_n};
   assign prod_s = (sa_q ^ sb_q) ? -prod : prod;
   assign quo    = (sa_q ^ sb_q) ? -lo_n : lo_n;
   assign rem    = sa_q ? -hi_n : hi_n;

   always_comb begin
      m_res = rem;
      case (mop_q)
         OP_MUL:                       m_res = prod_s[XLEN-1:0];
         OP_MULH, OP_MULHSU, OP_MULHU: m_res = prod_s[2*XLEN-1:XLEN];
         OP_DIV, OP_DIVU:              m_res = quo;
         default:                      m_res = rem;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= S_IDLE;
      else
         state <= state_n;
   end

   always_comb begin
      state_n = state;
      unique case (state)
         S_IDLE:
            if (accept && !fast)
               state_n = is_div ? S_DIV : S_MUL;
         S_MUL, S_DIV:
            if (cnt == LAST)
               state_n = S_IDLE;
         default: state_n = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt       <= '0;
         hi        <= '0;
         lo        <= '0;
         opnd      <= '0;
         sa_q      <= 1'b0;
         sb_q      <= 1'b0;
         mop_q     <= OP_ADD;
         out_valid <= 1'b0;
         result    <= '0;
         zero      <= 1'b0;
         illegal   <= 1'b0;
      end else begin
         if (accept && fast) begin
            result    <= bad ? '0 : fast_res;
            zero      <= bad || (fast_res == '0);
            illegal   <= bad;
            out_valid <= 1'b1;
         end else if (accept) begin
            cnt       <= '0;
            hi        <= '0;
            lo        <= a_neg ? -op_a : op_a;
            opnd      <= b_neg ? -op_b : op_b;
            sa_q      <= a_neg;
            sb_q      <= b_neg;
            mop_q     <= op;
            out_valid <= 1'b0;
         end else if (state != S_IDLE) begin
            cnt <= cnt + 1'b1;
            hi  <= hi_n;
            lo  <= lo_n;
            if (finish) begin
               result    <= m_res;
               zero      <= (m_res == '0);
               illegal   <= 1'b0;
               out_valid <= 1'b1;
            end
         end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_alu_exec_unit.sv
// tb_alu_exec_unit: scoreboard bench for alu_exec_unit (XLEN=32).
// Expected results come from a behavioural reference model.
module tb_alu_exec_unit;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid, in_ready, out_valid, out_ready;
   logic [1:0]  alu_op;
   logic [6:0]  func7;
   logic [2:0]  func3;
   logic [31:0] op_a, op_b, result;
   logic        zero, illegal;
   logic        n_ready, n_valid, n_zero, n_illegal;
   logic [31:0] n_result;

   always #5 clk = ~clk;

   alu_exec_unit #(.XLEN(32), .MDU_EN(1'b1)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .alu_op(alu_op), .func7(func7), .func3(func3), .op_a(op_a), .op_b(op_b),
      .out_valid(out_valid), .out_ready(out_ready), .result(result),
      .zero(zero), .illegal(illegal)
   );

   alu_exec_unit #(.XLEN(32), .MDU_EN(1'b0)) dut_nomdu (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(n_ready),
      .alu_op(alu_op), .func7(func7), .func3(func3), .op_a(op_a), .op_b(op_b),
      .out_valid(n_valid), .out_ready(1'b1), .result(n_result),
      .zero(n_zero), .illegal(n_illegal)
   );

   typedef struct {
      logic [31:0] res;
      logic        zero;
      logic        ill;
   } exp_t;

   localparam logic [31:0] MIN = 32'h8000_0000;

   exp_t sb[$];
   exp_t mon_e;
   int   n_cmp = 0;
   int   n_bad = 0;
   int   cyc = 0;
   int   acc_cyc = 0;

   always @(posedge clk) cyc++;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] base_ref(input logic [2:0] f3,
                                            input logic [31:0] a, b);
      case (f3)
         3'd0: return a + b;
         3'd1: return a << b[4:0];
         3'd2: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         3'd3: return (a < b) ? 32'd1 : 32'd0;
         3'd4: return a ^ b;
         3'd5: return a >> b[4:0];
         3'd6: return a | b;
         default: return a & b;
      endcase
   endfunction

   function automatic logic [31:0] m_ref(input logic [2:0] f3,
                                         input logic [31:0] a, b);
      logic [63:0] sa, sbv, ua, ub, p;
      logic        ovf;
      sa  = {{32{a[31]}}, a};
      sbv = {{32{b[31]}}, b};
      ua  = {32'b0, a};
      ub  = {32'b0, b};
      ovf = (a == MIN) && (b == 32'hFFFF_FFFF);
      p   = 64'd0;
      case (f3)
         3'd0: begin p = ua * ub; return p[31:0]; end
         3'd1: begin p = sa * sbv; return p[63:32]; end
         3'd2: begin p = sa * ub; return p[63:32]; end
         3'd3: begin p = ua * ub; return p[63:32]; end
         3'd4: begin
            if (b == 0) return 32'hFFFF_FFFF;
            if (ovf) return MIN;
            return $signed(a) / $signed(b);
         end
         3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
         3'd6: begin
            if (b == 0) return a;
            if (ovf) return 32'd0;
            return $signed(a) % $signed(b);
         end
         default: return (b == 0) ? a : a % b;
      endcase
   endfunction

   task automatic model(input logic [1:0] aop, input logic [6:0] f7,
                        input logic [2:0] f3, input logic [31:0] a, b,
                        output logic [31:0] r, output logic ill);
      r   = 32'd0;
      ill = 1'b0;
      case (aop)
         2'd0: r = a + b;
         2'd1: r = a - b;
         2'd2: begin
            if (f7 == 7'h00) r = base_ref(f3, a, b);
            else if (f7 == 7'h20 && f3 == 3'd0) r = a - b;
            else if (f7 == 7'h20 && f3 == 3'd5) r = $signed(a) >>> b[4:0];
            else if (f7 == 7'h01) r = m_ref(f3, a, b);
            else ill = 1'b1;
         end
         default: begin
            if (f3 == 3'd1) begin
               if (f7 == 7'h00) r = a << b[4:0];
               else ill = 1'b1;
            end else if (f3 == 3'd5) begin
               if (f7 == 7'h00) r = a >> b[4:0];
               else if (f7 == 7'h20) r = $signed(a) >>> b[4:0];
               else ill = 1'b1;
            end else begin
               r = base_ref(f3, a, b);
            end
         end
      endcase
      if (ill) r = 32'd0;
   endtask

   task automatic drive(input logic [1:0] aop, input logic [6:0] f7,
                        input logic [2:0] f3, input logic [31:0] a, b);
      logic [31:0] r;
      logic        ill;
      exp_t        e;
      int          k;
      model(aop, f7, f3, a, b, r, ill);
      alu_op   = aop;
      func7    = f7;
      func3    = f3;
      op_a     = a;
      op_b     = b;
      in_valid = 1'b1;
      k = 0;
      while (!in_ready && k < 500) begin
         @(negedge clk);
         k++;
      end
      if (k >= 500) begin
         check("accept_timeout", 32'd0, 32'd1);
         in_valid = 1'b0;
         return;
      end
      e.res  = r;
      e.zero = (r == 32'd0);
      e.ill  = ill;
      sb.push_back(e);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      acc_cyc  = cyc;
   endtask

   task automatic wait_valid(output int n, output int lows);
      n    = 0;
      lows = 0;
      while (n < 100) begin
         @(negedge clk);
         n++;
         if (out_valid) break;
         if (!in_ready) lows++;
      end
   endtask

   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         if (sb.size() == 0) begin
            check("sb_underflow", 32'd1, 32'd0);
         end else begin
            mon_e = sb.pop_front();
            check("result", result, mon_e.res);
            check("zero", {31'b0, zero}, {31'b0, mon_e.zero});
            check("illegal", {31'b0, illegal}, {31'b0, mon_e.ill});
         end
      end
   end

   initial begin
      int a0, n, lows, good, k;
      logic [6:0] f7r;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      alu_op    = 2'd0;
      func7     = 7'd0;
      func3     = 3'd0;
      op_a      = 32'd0;
      op_b      = 32'd0;
      repeat (2) @(negedge clk);
      check("rst_valid", {31'b0, out_valid}, 32'd0);
      check("rst_result", result, 32'd0);
      check("rst_zero", {31'b0, zero}, 32'd0);
      check("rst_illegal", {31'b0, illegal}, 32'd0);
      check("rst_in_ready", {31'b0, in_ready}, 32'd1);
      rst_n = 1'b1;
      @(negedge clk);

      drive(2'd0, 7'h00, 3'd0, 32'd5, 32'd7);
      a0 = acc_cyc;
      check("add_lat_valid", {31'b0, out_valid}, 32'd1);
      check("add_result", result, 32'd12);
      drive(2'd1, 7'h00, 3'd0, 32'd7, 32'd7);
      check("throughput", acc_cyc - a0, 32'd1);
      check("sub_zero", {31'b0, zero}, 32'd1);

      drive(2'd2, 7'h20, 3'd5, 32'h8000_0000, 32'd4);
      check("sra_result", result, 32'hF800_0000);
      drive(2'd2, 7'h00, 3'd3, 32'd1, 32'hFFFF_FFFF);
      check("sltu_result", result, 32'd1);
      drive(2'd2, 7'h00, 3'd2, 32'd1, 32'hFFFF_FFFF);
      check("slt_result", result, 32'd0);

      for (int i = 0; i < 40; i++) begin
         case ($urandom_range(0, 3))
            0: f7r = 7'h00;
            1: f7r = 7'h20;
            2: f7r = 7'h01;
            default: f7r = 7'($urandom);
         endcase
         drive(2'($urandom), f7r, 3'($urandom), $urandom,
               ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3))
                                           : $urandom);
      end

      drive(2'd2, 7'h01, 3'd1, 32'hFFFF_FFFE, 32'd3);
      check("nomdu_illegal", {31'b0, n_illegal}, 32'd1);
      check("nomdu_result", n_result, 32'd0);
      check("nomdu_zero", {31'b0, n_zero}, 32'd1);
      wait_valid(n, lows);
      check("mulh_latency", n, 32'd33);
      check("mulh_in_ready_low", lows, 32'd32);
      drive(2'd2, 7'h01, 3'd0, 32'h0001_0000, 32'h0001_0000);
      wait_valid(n, lows);
      check("mul_latency", n, 32'd33);

      drive(2'd2, 7'h01, 3'd4, -32'sd7, 32'd2);
      drive(2'd2, 7'h01, 3'd6, -32'sd7, 32'd2);
      drive(2'd2, 7'h01, 3'd5, 32'd7, 32'd0);
      wait_valid(n, lows);
      check("divu0_latency", n, 32'd1);
      drive(2'd2, 7'h01, 3'd4, MIN, 32'hFFFF_FFFF);
      wait_valid(n, lows);
      check("divovf_latency", n, 32'd1);
      drive(2'd2, 7'h01, 3'd6, MIN, 32'hFFFF_FFFF);

      k = 0;
      while (sb.size() != 0 && k < 200) begin
         @(negedge clk);
         k++;
      end
      out_ready = 1'b0;
      drive(2'd0, 7'h00, 3'd0, 32'd100, 32'd23);
      good = 0;
      for (int i = 0; i < 5; i++) begin
         alu_op   = 2'd0;
         op_a     = 32'd1;
         op_b     = 32'd1;
         in_valid = 1'b1;
         @(negedge clk);
         if (out_valid && result == 32'd123 && !in_ready) good++;
      end
      in_valid = 1'b0;
      check("stall_hold", good, 32'd5);
      out_ready = 1'b1;
      @(negedge clk);

      drive(2'd2, 7'h01, 3'd4, 32'd100, 32'd7);
      repeat (10) @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("abort_valid", {31'b0, out_valid}, 32'd0);
      check("abort_result", result, 32'd0);
      check("abort_zero", {31'b0, zero}, 32'd0);
      check("abort_illegal", {31'b0, illegal}, 32'd0);
      sb.delete();
      @(negedge clk);
      rst_n = 1'b1;
      drive(2'd0, 7'h00, 3'd0, 32'd40, 32'd2);
      check("post_rst_valid", {31'b0, out_valid}, 32'd1);
      check("post_rst_result", result, 32'd42);

      k = 0;
      while (sb.size() != 0 && k < 200) begin
         @(negedge clk);
         k++;
      end
      check("sb_drain", sb.size(), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
